// File: rtl/cdb_pkg.sv
// Shared field layout and helpers for the common data bus word.
// Pure definitions: no latency, no state.
// Not applicable: holds no flow-control logic.
package cdb_pkg;

    // CDB word layout: {dest_onehot[2:0], position[1:0], source, result[9:0]}
    localparam int CDB_DEST_MSB = 15;
    localparam int CDB_DEST_LSB = 13;
    localparam int CDB_POS_MSB  = 12;
    localparam int CDB_POS_LSB  = 11;
    localparam int CDB_SRC      = 10;
    localparam int CDB_DATA_MSB = 9;
    localparam int CDB_DATA_LSB = 0;

    localparam logic        SRC_SUMSUB = 1'b1;
    localparam logic        SRC_LDSD   = 1'b0;
    localparam logic [15:0] CDB_IDLE   = 16'h0000;

    // FIFO payload: {dest_onehot, position, result}; the source bit is added at the output
    localparam int PAYLOAD_W = 15;

    // Register index to the one-hot form the reservation station decodes; illegal -> 000
    function automatic logic [2:0] dest_onehot(input logic [2:0] dest);
        logic [2:0] oh;
        case (dest)
            3'd0:    oh = 3'b100;
            3'd1:    oh = 3'b010;
            3'd2:    oh = 3'b001;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Small per-source result queue feeding the CDB arbiter.
// Latency: a word written at an edge is visible at the head after that edge (no bypass).
// Backpressure: ready = count < DEPTH, independent of push; pushes while full are ignored.
module cdb_result_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = PAYLOAD_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         ready,
    output logic                         nonempty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign ready    = (count < CW'(DEPTH));
    assign nonempty = (count != '0);
    assign do_push  = push && ready && !flush;
    assign do_pop   = pop && nonempty && !flush;
    assign head     = mem[rd_ptr];

    // Storage array; contents are don't-care while the queue is empty
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; flush wins over push/pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Queues sum/sub and load/store results and drives at most one onto the CDB per cycle.
// Latency: push at edge N -> earliest CDB word registered at edge N+1.
// Backpressure: per-source ready = FIFO not full; no same-cycle pop credit.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int FAIR  = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         sumsub_valid,
    output logic                         sumsub_ready,
    input  logic [2:0]                   sumsub_reg_dest,
    input  logic [1:0]                   sumsub_position,
    input  logic [9:0]                   sumsub_result,
    input  logic                         ldsd_valid,
    output logic                         ldsd_ready,
    input  logic [2:0]                   ldsd_reg_dest,
    input  logic [1:0]                   ldsd_position,
    input  logic [9:0]                   ldsd_result,
    output logic [15:0]                  cdb,
    output logic                         grant_sumsub,
    output logic                         grant_ldsd,
    output logic                         drop_pulse,
    output logic [$clog2(DEPTH+1)-1:0]   sumsub_count,
    output logic [$clog2(DEPTH+1)-1:0]   ldsd_count
);

    logic                 ss_legal, ld_legal;
    logic                 ss_accept, ld_accept;
    logic                 ss_push, ld_push;
    logic                 drop_next;
    logic [PAYLOAD_W-1:0] ss_payload, ld_payload;
    logic [PAYLOAD_W-1:0] ss_head, ld_head;
    logic                 ss_nonempty, ld_nonempty;
    logic                 gnt_ss, gnt_ld;
    logic                 last_grant;

    // Illegal destinations are handshaken (so the unit is not stalled) but never stored
    assign ss_legal   = (sumsub_reg_dest <= 3'd2);
    assign ld_legal   = (ldsd_reg_dest <= 3'd2);
    assign ss_accept  = sumsub_valid && sumsub_ready && !flush;
    assign ld_accept  = ldsd_valid && ldsd_ready && !flush;
    assign ss_push    = ss_accept && ss_legal;
    assign ld_push    = ld_accept && ld_legal;
    assign drop_next  = (ss_accept && !ss_legal) || (ld_accept && !ld_legal);
    assign ss_payload = {dest_onehot(sumsub_reg_dest), sumsub_position, sumsub_result};
    assign ld_payload = {dest_onehot(ldsd_reg_dest), ldsd_position, ldsd_result};

    cdb_result_fifo #(.DEPTH(DEPTH), .WIDTH(PAYLOAD_W)) u_sumsub_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (ss_push),
        .push_data (ss_payload),
        .pop       (gnt_ss),
        .head      (ss_head),
        .ready     (sumsub_ready),
        .nonempty  (ss_nonempty),
        .count     (sumsub_count)
    );

    cdb_result_fifo #(.DEPTH(DEPTH), .WIDTH(PAYLOAD_W)) u_ldsd_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (ld_push),
        .push_data (ld_payload),
        .pop       (gnt_ld),
        .head      (ld_head),
        .ready     (ldsd_ready),
        .nonempty  (ld_nonempty),
        .count     (ldsd_count)
    );

    // Pick a winner from the pre-edge heads: round-robin on a tie, or load/store first
    always_comb begin
        gnt_ss = 1'b0;
        gnt_ld = 1'b0;
        if (!flush) begin
            if (ss_nonempty && ld_nonempty) begin
                if (FAIR != 0) begin
                    gnt_ss = (last_grant == SRC_LDSD);
                    gnt_ld = (last_grant == SRC_SUMSUB);
                end else begin
                    gnt_ld = 1'b1;
                end
            end else begin
                gnt_ss = ss_nonempty;
                gnt_ld = ld_nonempty;
            end
        end
    end

    // Register the bus word, grant flags, drop flag and round-robin history
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb          <= CDB_IDLE;
            grant_sumsub <= 1'b0;
            grant_ldsd   <= 1'b0;
            drop_pulse   <= 1'b0;
            last_grant   <= SRC_LDSD;
        end else if (flush) begin
            cdb          <= CDB_IDLE;
            grant_sumsub <= 1'b0;
            grant_ldsd   <= 1'b0;
            drop_pulse   <= 1'b0;
            last_grant   <= SRC_LDSD;
        end else begin
            grant_sumsub <= gnt_ss;
            grant_ldsd   <= gnt_ld;
            drop_pulse   <= drop_next;
            if (gnt_ss) begin
                cdb        <= {ss_head[14:10], SRC_SUMSUB, ss_head[9:0]};
                last_grant <= SRC_SUMSUB;
            end else if (gnt_ld) begin
                cdb        <= {ld_head[14:10], SRC_LDSD, ld_head[9:0]};
                last_grant <= SRC_LDSD;
            end else begin
                cdb        <= CDB_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        sumsub_valid = 1'b0;
    logic [2:0]  sumsub_reg_dest = '0;
    logic [1:0]  sumsub_position = '0;
    logic [9:0]  sumsub_result = '0;
    logic        ldsd_valid = 1'b0;
    logic [2:0]  ldsd_reg_dest = '0;
    logic [1:0]  ldsd_position = '0;
    logic [9:0]  ldsd_result = '0;

    logic        sumsub_ready, ldsd_ready;
    logic [15:0] cdb;
    logic        grant_sumsub, grant_ldsd, drop_pulse;
    logic [1:0]  sumsub_count, ldsd_count;

    logic        fp_sumsub_ready, fp_ldsd_ready;
    logic [15:0] fp_cdb;
    logic        fp_grant_sumsub, fp_grant_ldsd, fp_drop_pulse;
    logic [1:0]  fp_sumsub_count, fp_ldsd_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] rr_exp [4] = '{16'h2C11, 16'h40AA, 16'h9FFF, 16'h3200};
    logic        rr_ss  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] fp_exp [4] = '{16'h40AA, 16'h3200, 16'h2C11, 16'h9FFF};

    always #5 clock = ~clock;

    cdb_arbiter #(.DEPTH(2), .FAIR(1)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .sumsub_valid(sumsub_valid), .sumsub_ready(sumsub_ready),
        .sumsub_reg_dest(sumsub_reg_dest), .sumsub_position(sumsub_position),
        .sumsub_result(sumsub_result),
        .ldsd_valid(ldsd_valid), .ldsd_ready(ldsd_ready),
        .ldsd_reg_dest(ldsd_reg_dest), .ldsd_position(ldsd_position),
        .ldsd_result(ldsd_result),
        .cdb(cdb), .grant_sumsub(grant_sumsub), .grant_ldsd(grant_ldsd),
        .drop_pulse(drop_pulse), .sumsub_count(sumsub_count), .ldsd_count(ldsd_count)
    );

    cdb_arbiter #(.DEPTH(2), .FAIR(0)) dut_fp (
        .clock(clock), .reset(reset), .flush(flush),
        .sumsub_valid(sumsub_valid), .sumsub_ready(fp_sumsub_ready),
        .sumsub_reg_dest(sumsub_reg_dest), .sumsub_position(sumsub_position),
        .sumsub_result(sumsub_result),
        .ldsd_valid(ldsd_valid), .ldsd_ready(fp_ldsd_ready),
        .ldsd_reg_dest(ldsd_reg_dest), .ldsd_position(ldsd_position),
        .ldsd_result(ldsd_result),
        .cdb(fp_cdb), .grant_sumsub(fp_grant_sumsub), .grant_ldsd(fp_grant_ldsd),
        .drop_pulse(fp_drop_pulse), .sumsub_count(fp_sumsub_count), .ldsd_count(fp_ldsd_count)
    );

    // Expected bus word for the idx-th word of a source in the wrap test
    function automatic logic [15:0] mk(input int idx, input logic src);
        logic [2:0] oh;
        logic [1:0] pos;
        logic [9:0] dat;
        case (idx % 3)
            0:       oh = 3'b100;
            1:       oh = 3'b010;
            default: oh = 3'b001;
        endcase
        pos = 2'(idx % 4);
        dat = src ? 10'(idx + 'h100) : 10'(idx + 'h200);
        return {oh, pos, src, dat};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_ss(input logic v, input logic [2:0] d, input logic [1:0] p, input logic [9:0] r);
        sumsub_valid = v; sumsub_reg_dest = d; sumsub_position = p; sumsub_result = r;
    endtask

    task automatic drive_ld(input logic v, input logic [2:0] d, input logic [1:0] p, input logic [9:0] r);
        ldsd_valid = v; ldsd_reg_dest = d; ldsd_position = p; ldsd_result = r;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (cdb !== 16'h0000) begin errors++; $display("FAIL reset_cdb: got %h want 0000", cdb); end
        checks++; if ({grant_sumsub, grant_ldsd, drop_pulse} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {grant_sumsub, grant_ldsd, drop_pulse}); end
        checks++; if ({sumsub_count, ldsd_count} !== 4'b0000) begin errors++; $display("FAIL reset_counts: got %b want 0000", {sumsub_count, ldsd_count}); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_sumsub();
        drive_ss(1'b1, 3'd1, 2'd2, 10'h155);
        tick();
        drive_ss(1'b0, 3'd0, 2'd0, 10'h000);
        checks++; if (cdb !== 16'h0000) begin errors++; $display("FAIL ss_no_bypass: got %h want 0000", cdb); end
        checks++; if (sumsub_count !== 2'd1) begin errors++; $display("FAIL ss_count1: got %0d want 1", sumsub_count); end
        tick();
        checks++; if (cdb !== 16'h5555) begin errors++; $display("FAIL ss_cdb: got %h want 5555", cdb); end
        checks++; if ({grant_sumsub, grant_ldsd} !== 2'b10) begin errors++; $display("FAIL ss_grant: got %b want 10", {grant_sumsub, grant_ldsd}); end
        tick();
        checks++; if (cdb !== 16'h0000) begin errors++; $display("FAIL ss_pulse_end: got %h want 0000", cdb); end
        checks++; if (grant_sumsub !== 1'b0) begin errors++; $display("FAIL ss_grant_end: got %b want 0", grant_sumsub); end
    endtask

    task automatic test_single_ldsd();
        drive_ld(1'b1, 3'd0, 2'd0, 10'h003);
        tick();
        drive_ld(1'b0, 3'd0, 2'd0, 10'h000);
        tick();
        checks++; if (cdb !== 16'h8003) begin errors++; $display("FAIL ld_cdb: got %h want 8003", cdb); end
        checks++; if ({grant_sumsub, grant_ldsd} !== 2'b01) begin errors++; $display("FAIL ld_grant: got %b want 01", {grant_sumsub, grant_ldsd}); end
        tick();
        checks++; if ({cdb, grant_ldsd} !== 17'h0) begin errors++; $display("FAIL ld_pulse_end: got %h/%b want 0000/0", cdb, grant_ldsd); end
    endtask

    task automatic test_arbitration();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive_ss(1'b1, 3'd2, 2'd1, 10'h011);
        drive_ld(1'b1, 3'd1, 2'd0, 10'h0AA);
        tick();
        drive_ss(1'b1, 3'd0, 2'd3, 10'h3FF);
        drive_ld(1'b1, 3'd2, 2'd2, 10'h200);
        tick();
        drive_ss(1'b0, 3'd0, 2'd0, 10'h000);
        drive_ld(1'b0, 3'd0, 2'd0, 10'h000);
        for (int i = 0; i < 4; i++) begin
            checks++; if (cdb !== rr_exp[i]) begin errors++; $display("FAIL rr_cdb[%0d]: got %h want %h", i, cdb, rr_exp[i]); end
            checks++; if ({grant_sumsub, grant_ldsd} !== {rr_ss[i], ~rr_ss[i]}) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, {grant_sumsub, grant_ldsd}, {rr_ss[i], ~rr_ss[i]}); end
            checks++; if (fp_cdb !== fp_exp[i]) begin errors++; $display("FAIL fp_cdb[%0d]: got %h want %h", i, fp_cdb, fp_exp[i]); end
            tick();
        end
        checks++; if ({cdb, fp_cdb} !== 32'h0) begin errors++; $display("FAIL arb_idle: got %h/%h want 0000/0000", cdb, fp_cdb); end
    endtask

    task automatic test_backpressure_wrap();
        int  ss_sent = 0, ld_sent = 0, ss_got = 0, ld_got = 0, cyc = 0;
        bit  saw_full = 1'b0;
        bit  acc_ss, acc_ld;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        while ((ss_got < 10 || ld_got < 10) && cyc < 200) begin
            checks++; if (sumsub_ready !== (sumsub_count < 2'd2)) begin errors++; $display("FAIL bp_ready: got %b count %0d", sumsub_ready, sumsub_count); end
            if (sumsub_count == 2'd2 && sumsub_ready == 1'b0) saw_full = 1'b1;
            if (grant_sumsub && grant_ldsd) begin
                checks++; errors++; $display("FAIL bp_double_grant: got 11 want one-hot");
            end
            if (grant_sumsub) begin
                checks++; if (cdb !== mk(ss_got, 1'b1)) begin errors++; $display("FAIL bp_ss_order[%0d]: got %h want %h", ss_got, cdb, mk(ss_got, 1'b1)); end
                ss_got++;
            end
            if (grant_ldsd) begin
                checks++; if (cdb !== mk(ld_got, 1'b0)) begin errors++; $display("FAIL bp_ld_order[%0d]: got %h want %h", ld_got, cdb, mk(ld_got, 1'b0)); end
                ld_got++;
            end
            drive_ss(ss_sent < 10, 3'(ss_sent % 3), 2'(ss_sent % 4), 10'(ss_sent + 'h100));
            drive_ld(ld_sent < 10, 3'(ld_sent % 3), 2'(ld_sent % 4), 10'(ld_sent + 'h200));
            acc_ss = sumsub_valid && sumsub_ready;
            acc_ld = ldsd_valid && ldsd_ready;
            tick();
            if (acc_ss) ss_sent++;
            if (acc_ld) ld_sent++;
            cyc++;
        end
        drive_ss(1'b0, 3'd0, 2'd0, 10'h000);
        drive_ld(1'b0, 3'd0, 2'd0, 10'h000);
        checks++; if (ss_got != 10 || ld_got != 10) begin errors++; $display("FAIL bp_complete: got ss %0d ld %0d want 10/10 within 200 cycles", ss_got, ld_got); end
        checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL bp_full_seen: got %b want 1", saw_full); end
        tick();
        tick();
    endtask

    task automatic test_drop();
        drive_ss(1'b1, 3'd5, 2'd1, 10'h3FF);
        tick();
        drive_ss(1'b0, 3'd0, 2'd0, 10'h000);
        checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL drop_set: got %b want 1", drop_pulse); end
        checks++; if (sumsub_count !== 2'd0) begin errors++; $display("FAIL drop_count: got %0d want 0", sumsub_count); end
        tick();
        checks++; if ({drop_pulse, cdb} !== 17'h0) begin errors++; $display("FAIL drop_clear: got %b/%h want 0/0000", drop_pulse, cdb); end
        drive_ss(1'b1, 3'd7, 2'd0, 10'h001);
        drive_ld(1'b1, 3'd3, 2'd0, 10'h002);
        tick();
        drive_ss(1'b0, 3'd0, 2'd0, 10'h000);
        drive_ld(1'b0, 3'd0, 2'd0, 10'h000);
        checks++; if ({drop_pulse, sumsub_count, ldsd_count} !== 5'b10000) begin errors++; $display("FAIL drop_both: got %b want 10000", {drop_pulse, sumsub_count, ldsd_count}); end
        tick();
        checks++; if ({drop_pulse, cdb} !== 17'h0) begin errors++; $display("FAIL drop_single: got %b/%h want 0/0000", drop_pulse, cdb); end
        drive_ss(1'b1, 3'd6, 2'd0, 10'h001);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive_ss(1'b0, 3'd0, 2'd0, 10'h000);
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL drop_under_flush: got %b want 0", drop_pulse); end
    endtask

    task automatic test_flush();
        drive_ss(1'b1, 3'd2, 2'd0, 10'h001);
        tick();
        drive_ss(1'b0, 3'd0, 2'd0, 10'h000);
        tick();
        tick();
        drive_ss(1'b1, 3'd0, 2'd1, 10'h0F0);
        drive_ld(1'b1, 3'd1, 2'd1, 10'h00F);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive_ss(1'b0, 3'd0, 2'd0, 10'h000);
        drive_ld(1'b0, 3'd0, 2'd0, 10'h000);
        checks++; if ({sumsub_count, ldsd_count} !== 4'b0000) begin errors++; $display("FAIL flush_counts: got %b want 0000", {sumsub_count, ldsd_count}); end
        checks++; if ({cdb, grant_sumsub, grant_ldsd} !== 18'h0) begin errors++; $display("FAIL flush_out: got %h/%b%b want 0000/00", cdb, grant_sumsub, grant_ldsd); end
        tick();
        checks++; if (cdb !== 16'h0000) begin errors++; $display("FAIL flush_idle: got %h want 0000", cdb); end
        drive_ss(1'b1, 3'd1, 2'd2, 10'h155);
        drive_ld(1'b1, 3'd0, 2'd0, 10'h003);
        tick();
        drive_ss(1'b0, 3'd0, 2'd0, 10'h000);
        drive_ld(1'b0, 3'd0, 2'd0, 10'h000);
        tick();
        checks++; if (cdb !== 16'h5555) begin errors++; $display("FAIL flush_last_grant: got %h want 5555", cdb); end
        tick();
        checks++; if (cdb !== 16'h8003) begin errors++; $display("FAIL flush_second: got %h want 8003", cdb); end
        tick();
    endtask

    task automatic test_async_reset();
        drive_ss(1'b1, 3'd1, 2'd2, 10'h155);
        tick();
        drive_ss(1'b0, 3'd0, 2'd0, 10'h000);
        tick();
        checks++; if (cdb !== 16'h5555) begin errors++; $display("FAIL areset_pre: got %h want 5555", cdb); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({cdb, grant_sumsub} !== 17'h0) begin errors++; $display("FAIL areset_cdb: got %h/%b want 0000/0", cdb, grant_sumsub); end
        reset = 1'b1;
        tick();
        checks++; if (cdb !== 16'h0000) begin errors++; $display("FAIL areset_after: got %h want 0000", cdb); end
    endtask

    initial begin
        test_reset();
        test_single_sumsub();
        test_single_ldsd();
        test_arbitration();
        test_backpressure_wrap();
        test_drop();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the 16-bit common data bus between the two functional units fed by the reservation station: the sum/sub ULA and the load/store ULA. Each unit pushes its results into a private small FIFO. A registered round-robin arbiter drives at most one result onto the CDB per cycle, in the exact field format the reservation station decodes. The block sits between the ULA outputs and the `cdb` input of the reservation station and bank of registers.

Parameters:
- DEPTH, 2: entries per source FIFO (power of two, ≥2).
- FAIR, 1: 1 = round-robin; 0 = fixed priority, load/store first.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of FIFOs and arbiter state
- sumsub_valid  in  1  sum/sub result offered
- sumsub_ready  out  1  sum/sub FIFO can accept
- sumsub_reg_dest  in  3  destination register index
- sumsub_position  in  2  RS slot of the instruction
- sumsub_result  in  10  result data
- ldsd_valid  in  1  load/store word offered (address word or data word)
- ldsd_ready  out  1  load/store FIFO can accept
- ldsd_reg_dest  in  3  destination register index
- ldsd_position  in  2  RS slot
- ldsd_result  in  10  address or data
- cdb  out  16  bus word; 16'h0000 = idle
- grant_sumsub  out  1  cdb this cycle came from sum/sub
- grant_ldsd  out  1  cdb this cycle came from load/store
- drop_pulse  out  1  one-cycle flag: a push had illegal reg_dest
- sumsub_count  out  $clog2(DEPTH+1)  sum/sub FIFO occupancy
- ldsd_count  out  $clog2(DEPTH+1)  load/store FIFO occupancy

Behaviour:
- Reset (reset=0, async): all outputs 0, both FIFOs empty, last_grant = ldsd, so the first tie goes to sum/sub.
- CDB word format:
  - cdb[15:13] is the one-hot destination: dest 0→100, 1→010, 2→001.
  - cdb[12:11] = position.
  - cdb[10] = source (1 sum/sub, 0 load/store).
  - cdb[9:0] = result.
- Push: valid&&ready at edge N writes the FIFO tail. `ready` = (count < DEPTH). There is no combinational dependence on `valid` and no same-cycle pop credit.
- Illegal dest (reg_dest > 2) on a handshake:
  - The word is accepted but not stored.
  - drop_pulse = 1 during cycle N+1.
  - Both sources dropping in the same cycle still gives a single pulse.
- No bypass: a word pushed at edge N can appear on cdb no earlier than cycle N+1→N+2 (registered at edge N+1).
- Arbitration at every edge, using pre-edge FIFO heads:
  - Neither FIFO non-empty: cdb←0, both grants←0.
  - Exactly one non-empty: that FIFO pops; cdb←its word; its grant←1.
  - Both non-empty, FAIR=1: grant the source ≠ last_grant. last_grant updates only on a grant.
  - Both non-empty, FAIR=0: grant load/store.
- cdb is a single-cycle pulse per result. Back-to-back results from one source give consecutive non-zero cycles.
- Per-source ordering is strictly FIFO, so a load's address word always precedes its data word.
- Push and pop of the same FIFO in one edge: count unchanged, both happen.
- Pointers wrap modulo DEPTH.
- flush=1 at an edge:
  - FIFOs emptied; pushes in that cycle discarded (no drop_pulse).
  - cdb, grants and drop_pulse ←0; last_grant ← ldsd.
  - flush has priority over push and arbitration.
- Reset asserted mid-operation clears everything immediately, including in-flight cdb.

Decomposition:
- Package cdb_pkg holds:
  - field constants CDB_DEST_MSB/LSB=15/13, CDB_POS=12:11, CDB_SRC=10, CDB_DATA=9:0;
  - SRC_SUMSUB=1'b1, SRC_LDSD=1'b0, CDB_IDLE=16'h0000;
  - function dest_onehot(3-bit)→3-bit (000 for illegal).
- Sub-module cdb_result_fifo (DEPTH, 15-bit payload {dest_onehot, position, result}, count output) is instantiated once per source. The arbiter and output register live in the top.

Test Plan:
- Single sum/sub push dest=1, pos=2, data=10'h155:
  - cdb=16'h5555 for exactly one cycle, two edges after the push edge;
  - grant_sumsub=1 that cycle; then cdb=0.
- Single load/store push dest=0, pos=0, data=10'h003 → cdb=16'h8003, grant_ldsd=1 for one cycle.
- Both FIFOs full (2 each), no more pushes, FAIR=1 → grants alternate sumsub, ldsd, sumsub, ldsd on four consecutive cycles, then cdb=0. With FAIR=0 the order is ldsd, ldsd, sumsub, sumsub.
- Fill sum/sub with 2 words, hold valid → sumsub_ready=0, count=2, third word not lost; accepted the cycle after a pop frees a slot; pointer wrap verified over 10 words in order.
- Push dest=5 → drop_pulse=1 one cycle, count unchanged, cdb stays 0.
- Two words queued, flush=1 for one cycle → counts 0, cdb 0 thereafter. Assert reset=0 while cdb≠0 → cdb=0 immediately (asynchronous).
